// File: rtl/fp32_adder_pkg.sv
// rtl/fp32_adder_pkg.sv - shared FP32 field constants and widths for the dual-lane adder
// Purpose: single home for the IEEE-754 single field layout and the default
//          datapath widths used by the alignment stage and its lane datapath.
// Ports:   none (package).
package fp32_adder_pkg;

  // IEEE-754 single precision field layout
  localparam int FP_SIGN_BIT   = 31;
  localparam int FP_EXP_MSB    = 30;
  localparam int FP_EXP_LSB    = 23;
  localparam int FP_FRAC_MSB   = 22;
  localparam int FP_FRAC_LSB   = 0;
  localparam int FP_EXP_BIAS   = 127;

  // Default datapath widths
  localparam int DEF_EXPONENT_WIDTH = FP_EXP_MSB - FP_EXP_LSB + 1;
  localparam int DEF_MANTISA_WIDTH  = 24;

  // The aligned sum carries one extra bit so the signed result of two
  // sub-2^23 magnitudes always fits.
  localparam int SUM_SIGN_BITS = 1;
  localparam int DEF_SUM_WIDTH = DEF_MANTISA_WIDTH + SUM_SIGN_BITS;

endpackage

// File: rtl/fp32_align_lane.sv
// rtl/fp32_align_lane.sv - combinational unpack/compare and shift/add datapath for one lane
// Purpose: front part (unpack, pick big operand, exponent difference) feeds the
//          stage-1 registers; back part (align small, sign terms, add) consumes
//          the stage-1 registers and produces the signed aligned sum.
// Ports:
//   i_a, i_b          FP32 operands of this lane
//   o_big_*/o_small_* unpacked big/small operand fields (to stage-1 registers)
//   o_diff            exponent difference exp_big - exp_small
//   i_big_*/i_small_*, i_diff  registered stage-1 fields
//   o_sum             signed two's-complement aligned mantissa sum
module fp32_align_lane
  import fp32_adder_pkg::*;
#(
  parameter int EW = DEF_EXPONENT_WIDTH,
  parameter int MW = DEF_MANTISA_WIDTH,
  parameter int SW = DEF_SUM_WIDTH
) (
  input  logic [31:0]   i_a,
  input  logic [31:0]   i_b,
  output logic          o_big_sign,
  output logic [EW-1:0] o_big_exp,
  output logic [MW-1:0] o_big_mag,
  output logic          o_small_sign,
  output logic [MW-1:0] o_small_mag,
  output logic [EW-1:0] o_diff,
  input  logic          i_big_sign,
  input  logic [MW-1:0] i_big_mag,
  input  logic          i_small_sign,
  input  logic [MW-1:0] i_small_mag,
  input  logic [EW-1:0] i_diff,
  output logic [SW-1:0] o_sum
);

  logic          w_sign_a, w_sign_b;
  logic [EW-1:0] w_exp_a, w_exp_b;
  logic [MW-1:0] w_mag_a, w_mag_b;
  logic          w_a_big;
  logic [EW-1:0] w_small_exp;
  logic          w_unused_frac_lsb;

  assign w_sign_a = i_a[FP_SIGN_BIT];
  assign w_sign_b = i_b[FP_SIGN_BIT];
  assign w_exp_a  = i_a[FP_EXP_LSB +: EW];
  assign w_exp_b  = i_b[FP_EXP_LSB +: EW];

  // Magnitude keeps a zero MSB as sum headroom, so the last fraction bit is
  // dropped. A zero exponent (zero or denormal) contributes nothing.
  assign w_mag_a = (w_exp_a == '0) ? '0 : {1'b0, 1'b1, i_a[FP_FRAC_MSB -: (MW-2)]};
  assign w_mag_b = (w_exp_b == '0) ? '0 : {1'b0, 1'b1, i_b[FP_FRAC_MSB -: (MW-2)]};
  assign w_unused_frac_lsb = i_a[FP_FRAC_LSB] ^ i_b[FP_FRAC_LSB];

  // Exponent tie selects a
  assign w_a_big = (w_exp_a >= w_exp_b);

  assign o_big_sign   = w_a_big ? w_sign_a : w_sign_b;
  assign o_big_exp    = w_a_big ? w_exp_a  : w_exp_b;
  assign o_big_mag    = w_a_big ? w_mag_a  : w_mag_b;
  assign o_small_sign = w_a_big ? w_sign_b : w_sign_a;
  assign o_small_mag  = w_a_big ? w_mag_b  : w_mag_a;
  assign w_small_exp  = w_a_big ? w_exp_b  : w_exp_a;
  assign o_diff       = o_big_exp - w_small_exp;

  logic          w_shift_out;
  logic [MW-1:0] w_small_aligned;
  logic [SW-1:0] w_big_ext, w_small_ext;
  logic [SW-1:0] w_big_term, w_small_term;

  assign w_shift_out     = (i_diff >= EW'(MW));
  assign w_small_aligned = w_shift_out ? '0 : (i_small_mag >> i_diff);

  // Magnitudes are unsigned, so sign extension is a zero pad
  assign w_big_ext   = {{(SW-MW){1'b0}}, i_big_mag};
  assign w_small_ext = {{(SW-MW){1'b0}}, w_small_aligned};

  assign w_big_term   = i_big_sign   ? (SW'(0) - w_big_ext)   : w_big_ext;
  assign w_small_term = i_small_sign ? (SW'(0) - w_small_ext) : w_small_ext;

  assign o_sum = w_big_term + w_small_term;

endmodule

// File: rtl/fp32_adder_dual_alignment_stage.sv
// rtl/fp32_adder_dual_alignment_stage.sv - two-lane FP32 adder alignment front end, 2-stage pipeline
// Purpose: unpack two independent operand pairs, pick the larger exponent,
//          align the smaller mantissa and form a signed mantissa sum per lane.
//          Both lanes share one valid/ready pipeline with a global stall.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             operand handshake
//   a_0, b_0, a_1, b_1            FP32 operands, lane 0 and lane 1
//   out_valid/out_ready           result handshake
//   exponent_big_0/1              larger biased exponent per lane
//   add_0/1                       signed aligned mantissa sum per lane
module fp32_adder_dual_alignment_stage
  import fp32_adder_pkg::*;
#(
  parameter int EXPONENT_WIDTH = DEF_EXPONENT_WIDTH,
  parameter int MANTISA_WIDTH  = DEF_MANTISA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [31:0]                            a_0,
  input  logic [31:0]                            b_0,
  input  logic [31:0]                            a_1,
  input  logic [31:0]                            b_1,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH-1:0]              exponent_big_0,
  output logic [EXPONENT_WIDTH-1:0]              exponent_big_1,
  output logic [MANTISA_WIDTH+SUM_SIGN_BITS-1:0] add_0,
  output logic [MANTISA_WIDTH+SUM_SIGN_BITS-1:0] add_1
);

  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = MANTISA_WIDTH;
  localparam int SW = MANTISA_WIDTH + SUM_SIGN_BITS;

  logic w_stall;

  // Lane operand views
  logic [1:0][31:0] w_a, w_b;
  assign w_a[0] = a_0;
  assign w_a[1] = a_1;
  assign w_b[0] = b_0;
  assign w_b[1] = b_1;

  // Stage-1 combinational fields
  logic [1:0]         w_big_sign, w_small_sign;
  logic [1:0][EW-1:0] w_big_exp, w_diff;
  logic [1:0][MW-1:0] w_big_mag, w_small_mag;
  logic [1:0][SW-1:0] w_sum;

  // Stage-1 registers
  logic               r_s1_valid;
  logic [1:0]         r_s1_big_sign, r_s1_small_sign;
  logic [1:0][EW-1:0] r_s1_big_exp, r_s1_diff;
  logic [1:0][MW-1:0] r_s1_big_mag, r_s1_small_mag;

  // Output registers
  logic               r_out_valid;
  logic [1:0][EW-1:0] r_exp_big;
  logic [1:0][SW-1:0] r_add;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    fp32_align_lane #(
      .EW (EW),
      .MW (MW),
      .SW (SW)
    ) u_lane (
      .i_a          (w_a[l]),
      .i_b          (w_b[l]),
      .o_big_sign   (w_big_sign[l]),
      .o_big_exp    (w_big_exp[l]),
      .o_big_mag    (w_big_mag[l]),
      .o_small_sign (w_small_sign[l]),
      .o_small_mag  (w_small_mag[l]),
      .o_diff       (w_diff[l]),
      .i_big_sign   (r_s1_big_sign[l]),
      .i_big_mag    (r_s1_big_mag[l]),
      .i_small_sign (r_s1_small_sign[l]),
      .i_small_mag  (r_s1_small_mag[l]),
      .i_diff       (r_s1_diff[l]),
      .o_sum        (w_sum[l])
    );
  end

  // A held output freezes the whole pipe, so nothing can be overwritten
  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid      <= 1'b0;
      r_s1_big_sign   <= '0;
      r_s1_small_sign <= '0;
      r_s1_big_exp    <= '0;
      r_s1_diff       <= '0;
      r_s1_big_mag    <= '0;
      r_s1_small_mag  <= '0;
      r_out_valid     <= 1'b0;
      r_exp_big       <= '0;
      r_add           <= '0;
    end else if (!w_stall) begin
      r_s1_valid      <= in_valid;
      r_s1_big_sign   <= w_big_sign;
      r_s1_small_sign <= w_small_sign;
      r_s1_big_exp    <= w_big_exp;
      r_s1_diff       <= w_diff;
      r_s1_big_mag    <= w_big_mag;
      r_s1_small_mag  <= w_small_mag;
      r_out_valid     <= r_s1_valid;
      r_exp_big       <= r_s1_big_exp;
      r_add           <= w_sum;
    end
  end

  assign out_valid      = r_out_valid;
  assign exponent_big_0 = r_exp_big[0];
  assign exponent_big_1 = r_exp_big[1];
  assign add_0          = r_add[0];
  assign add_1          = r_add[1];

endmodule

// File: tb/tb_fp32_adder_dual_alignment_stage.sv
// tb/tb_fp32_adder_dual_alignment_stage.sv - self-checking bench for the dual-lane alignment stage
module tb_fp32_adder_dual_alignment_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_0, b_0, a_1, b_1;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exponent_big_0, exponent_big_1;
  logic [24:0] add_0, add_1;

  fp32_adder_dual_alignment_stage #(
    .EXPONENT_WIDTH (8),
    .MANTISA_WIDTH  (24)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a_0            (a_0),
    .b_0            (b_0),
    .a_1            (a_1),
    .b_1            (b_1),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .exponent_big_0 (exponent_big_0),
    .exponent_big_1 (exponent_big_1),
    .add_0          (add_0),
    .add_1          (add_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a0, b0, a1, b1;
    logic [7:0]  e0;
    logic [24:0] s0;
    logic [7:0]  e1;
    logic [24:0] s1;
  } vec_t;

  typedef struct {
    logic [7:0]  e0;
    logic [24:0] s0;
    logic [7:0]  e1;
    logic [24:0] s1;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Independent reference: integer arithmetic on decoded fields
  function automatic logic [24:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, ma, mb, mbig, msml, d;
    logic sbig, ssml;
    logic signed [31:0] r;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 0 : int'((32'h0080_0000 | {9'd0, a[22:0]}) >> 1);
    mb = (eb == 0) ? 0 : int'((32'h0080_0000 | {9'd0, b[22:0]}) >> 1);
    if (ea >= eb) begin
      mbig = ma; msml = mb; sbig = a[31]; ssml = b[31]; d = ea - eb;
    end else begin
      mbig = mb; msml = ma; sbig = b[31]; ssml = a[31]; d = eb - ea;
    end
    msml = (d >= 24) ? 0 : (msml >> d);
    r = (sbig ? -mbig : mbig) + (ssml ? -msml : msml);
    return r[24:0];
  endfunction

  function automatic logic [7:0] model_exp(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] >= b[30:23]) ? a[30:23] : b[30:23];
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.e0 = v.e0; e.s0 = v.s0; e.e1 = v.e1; e.s1 = v.s1;
    return e;
  endfunction

  // Scoreboard consumer: outputs sampled mid-cycle, transfer lands on next edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got exp0=%h add0=%h want no output", exponent_big_0, add_0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("exp0", 32'(exponent_big_0), 32'(e.e0));
        check("add0", 32'(add_0), 32'(e.s0));
        check("exp1", 32'(exponent_big_1), 32'(e.e1));
        check("add1", 32'(add_1), 32'(e.s1));
      end
    end
  end

  // Entered and left at posedge+1
  task automatic send(input vec_t v);
    int n;
    a_0 = v.a0; b_0 = v.b0; a_1 = v.a1; b_1 = v.b1;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(to_exp(v));
        break;
      end
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got in_ready=0 want 1 within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  vec_t tbl[8];
  vec_t rnd;

  initial begin
    tbl[0] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 8'd127, 25'h0800000, 8'd127, 25'h0000000};
    tbl[1] = '{32'h3FC00000, 32'h3F000000, 32'h3F000000, 32'h3FC00000, 8'd127, 25'h0800000, 8'd127, 25'h0800000};
    tbl[2] = '{32'h3F000000, 32'hBFC00000, 32'h4B800000, 32'h3F800000, 8'd127, 25'h1C00000, 8'd151, 25'h0400000};
    tbl[3] = '{32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000, 8'd127, 25'h0400000, 8'd0,   25'h0000000};
    tbl[4] = '{32'h4A800000, 32'h3F800000, 32'hCA800000, 32'h3F800000, 8'd149, 25'h0400001, 8'd149, 25'h1C00001};
    tbl[5] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'hBFFFFFFF, 32'hBFFFFFFF, 8'd127, 25'h0FFFFFE, 8'd127, 25'h1000002};
    tbl[6] = '{32'h3F800000, 32'h40400000, 32'h7F800000, 32'h3F800000, 8'd128, 25'h0800000, 8'd255, 25'h0400000};
    tbl[7] = '{32'h4B000000, 32'h3F800000, 32'h3F800000, 32'h4B000000, 8'd150, 25'h0400000, 8'd150, 25'h0400000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_0 = '0; b_0 = '0; a_1 = '0; b_1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_exp0", 32'(exponent_big_0), 32'd0);
    check("rst_add1", 32'(add_1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at edge E, out_valid after edge E+1
    send(tbl[0]);
    in_valid = 1'b0;
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_two", 32'(out_valid), 32'd1);
    drain();

    // Table back-to-back
    for (int i = 0; i < 8; i++) send(tbl[i]);
    drain();

    // Swapped operands give identical results
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      v = tbl[i];
      v.a0 = tbl[i].b0; v.b0 = tbl[i].a0;
      v.a1 = tbl[i].b1; v.b1 = tbl[i].a1;
      if (tbl[i].a0[30:23] != tbl[i].b0[30:23] || i == 1) send(v);
    end
    drain();

    // Random operands with random backpressure
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          rnd.a0 = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
          rnd.b0 = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
          rnd.a1 = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
          rnd.b1 = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
          rnd.e0 = model_exp(rnd.a0, rnd.b0);
          rnd.s0 = model_sum(rnd.a0, rnd.b0);
          rnd.e1 = model_exp(rnd.a1, rnd.b1);
          rnd.s1 = model_sum(rnd.a1, rnd.b1);
          send(rnd);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Backpressure: 4 back-to-back, hold out_ready low 3 cycles at first result
    fork
      begin
        for (int i = 0; i < 4; i++) send(tbl[i + 2]);
        in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_first_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_hold_valid", 32'(out_valid), 32'd1);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_hold_add0", 32'(add_0), 32'(tbl[2].s0));
          check("bp_hold_exp1", 32'(exponent_big_1), 32'(tbl[2].e1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream discards in-flight work
    for (int i = 0; i < 3; i++) send(tbl[i + 4]);
    in_valid = 1'b0;
    check("mid_busy", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_add0", 32'(add_0), 32'd0);
    sb.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end

    // Recovery after reset
    send(tbl[1]);
    drain();

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
